// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port among NUM_REQ
// requesters. Define SPRITE_ARB_PRIO_EN to give requester 0 fixed priority.
module sprite_rom_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 12,
    parameter int MAX_WAIT = 15,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    output logic [IDX_W-1:0]          rid,
    output logic [NUM_REQ-1:0]        starve
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                ptr_adv;
    logic [NUM_REQ-1:0]  rr_req;
    logic [2*NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]    tag;
    logic [ADDR_W-1:0]   addr_a [NUM_REQ];
    logic [7:0]          wcnt [NUM_REQ];

    // Unpack the flattened address bus into one word per requester
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i] = addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Requests taking part in the rotating search
    always_comb begin
        rr_req = req;
`ifdef SPRITE_ARB_PRIO_EN
        rr_req[0] = 1'b0;
`endif
    end

    // Grant select: first requester at or after ptr, wrapping around
    always_comb begin
        int sel;
        int k;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        ptr_adv = 1'b0;
        sel     = 0;
        k       = 0;
        rot     = {rr_req, rr_req} >> ptr;
        if (reset_n) begin
`ifdef SPRITE_ARB_PRIO_EN
            if (req[0]) begin
                gnt_any = 1'b1;
            end
`endif
            if (!gnt_any) begin
                for (int o = 0; o < NUM_REQ; o++) begin
                    if (!ptr_adv && rot[o]) begin
                        ptr_adv = 1'b1;
                        sel     = o;
                    end
                end
                if (ptr_adv) begin
                    k = int'(ptr) + sel;
                    if (k >= NUM_REQ) begin
                        k = k - NUM_REQ;
                    end
                    gnt_idx = IDX_W'(k);
                    gnt_any = 1'b1;
                end
            end
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    // Round-robin pointer moves past the requester just served
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (ptr_adv) begin
            if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end

    // ROM request stage: launch the granted address, hold it when idle
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
            tag      <= '0;
        end else begin
            rom_en <= gnt_any;
            if (gnt_any) begin
                rom_addr <= addr_a[gnt_idx];
                tag      <= gnt_idx;
            end
        end
    end

    // Return stage: capture ROM data at the end of the rom_en cycle
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
        end else begin
            rvalid <= rom_en;
            if (rom_en) begin
                rdata <= rom_q;
                rid   <= tag;
            end
        end
    end

    // Per-requester wait counters and sticky starvation flags
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            starve <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || gnt[i]) begin
                    wcnt[i] <= '0;
                end else if (wcnt[i] < MAX_W) begin
                    wcnt[i] <= wcnt[i] + 8'd1;
                end
                if (wcnt[i] == MAX_W) begin
                    starve[i] <= 1'b1;
                end
            end
        end
    end

endmodule
